// File: rtl/req_rr_grant_pkg.sv
// Shared constants, FSM state type and index arithmetic for the round-robin
// request arbiter.
package req_rr_pkg;

   localparam int N     = 8;
   localparam int IDX_W = $clog2(N);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   // (a + b) mod N for indices already in range; works for non-power-of-two N.
   function automatic logic [IDX_W-1:0] idx_wrap_add(
      input logic [IDX_W-1:0] a,
      input logic [IDX_W-1:0] b
   );
      logic [IDX_W:0] sum;
      logic [IDX_W:0] res;
      sum = {1'b0, a} + {1'b0, b};
      if (sum >= (IDX_W+1)'(N)) begin
         res = sum - (IDX_W+1)'(N);
      end else begin
         res = sum;
      end
      return res[IDX_W-1:0];
   endfunction

endpackage

// File: rtl/req_rr_grant_if.sv
// Grant handshake bundle between the arbiter (master) and the encoder stage (slave).
interface req_rr_grant_if;
   import req_rr_pkg::*;

   logic [N-1:0]     grant_onehot;
   logic [IDX_W-1:0] grant_idx;
   logic             grant_valid;
   logic             grant_ready;

   modport master (
      output grant_onehot,
      output grant_idx,
      output grant_valid,
      input  grant_ready
   );

   modport slave (
      input  grant_onehot,
      input  grant_idx,
      input  grant_valid,
      output grant_ready
   );

endinterface

// File: rtl/req_rr_grant_pick.sv
// Combinational round-robin picker: rotate so start_i is bit 0, find the
// lowest set bit, then map the position back to an absolute index.
module req_rr_pick
   import req_rr_pkg::*;
(
   input  logic [N-1:0]     vector_i,
   input  logic [IDX_W-1:0] start_i,
   output logic [N-1:0]     onehot_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   logic [N-1:0]     rot_s;
   logic [IDX_W-1:0] pos_s;

   // Rotate, priority-find the lowest set bit, rotate the result back.
   always_comb begin
      rot_s = '0;
      for (int j = 0; j < N; j++) begin
         rot_s[j] = vector_i[idx_wrap_add(IDX_W'(j), start_i)];
      end
      pos_s = '0;
      for (int i = N-1; i >= 0; i--) begin
         pos_s = rot_s[i] ? IDX_W'(i) : pos_s;
      end
      any_o    = |rot_s;
      idx_o    = idx_wrap_add(pos_s, start_i);
      onehot_o = '0;
      if (any_o) begin
         onehot_o[idx_o] = 1'b1;
      end else begin
         onehot_o = '0;
      end
   end

endmodule

// File: rtl/req_rr_grant.sv
// Round-robin request arbiter: sticky pending register, two-state offer FSM
// and registered one-hot/index grant with valid/ready backpressure.
module req_rr_grant
   import req_rr_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req_in,
   req_rr_grant_if.master       gnt,
   output logic [N-1:0]         pending,
   output logic                 overflow
);

   state_t           state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [N-1:0]     pending_q;
   logic [N-1:0]     pending_d;
   logic             overflow_q;
   logic             overflow_d;
   logic [N-1:0]     onehot_q;
   logic [IDX_W-1:0] idx_q;
   logic             valid_q;

   logic             handshake_s;
   logic [N-1:0]     clr_s;
   logic [N-1:0]     pick_vec_s;
   logic [IDX_W-1:0] pick_start_s;
   logic [N-1:0]     pick_onehot_s;
   logic [IDX_W-1:0] pick_idx_s;
   logic             pick_any_s;

   // Pending/overflow next state; a same-cycle re-request beats the clear.
   always_comb begin
      handshake_s = valid_q & gnt.grant_ready;
      if (handshake_s) begin
         clr_s = onehot_q;
      end else begin
         clr_s = '0;
      end
      pending_d  = (pending_q & ~clr_s) | req_in;
      overflow_d = |(req_in & pending_q & ~clr_s);
   end

   // Select the picker operands: fresh search from ptr, or the successor search after an accept.
   always_comb begin
      if (state_q == OFFER) begin
         pick_vec_s   = pending_q & ~onehot_q;
         pick_start_s = idx_wrap_add(idx_q, IDX_W'(1));
      end else begin
         pick_vec_s   = pending_q;
         pick_start_s = ptr_q;
      end
   end

   req_rr_pick u_pick (
      .vector_i (pick_vec_s),
      .start_i  (pick_start_s),
      .onehot_o (pick_onehot_s),
      .idx_o    (pick_idx_s),
      .any_o    (pick_any_s)
   );

   // Sticky pending register and collision pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
      end
   end

   // Offer FSM with registered grant outputs; an offer holds until accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         onehot_q <= '0;
         idx_q    <= '0;
         valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any_s) begin
                  onehot_q <= pick_onehot_s;
                  idx_q    <= pick_idx_s;
                  valid_q  <= 1'b1;
                  state_q  <= OFFER;
               end else begin
                  onehot_q <= '0;
                  idx_q    <= '0;
                  valid_q  <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            OFFER: begin
               if (handshake_s) begin
                  ptr_q <= pick_start_s;
                  if (pick_any_s) begin
                     onehot_q <= pick_onehot_s;
                     idx_q    <= pick_idx_s;
                     valid_q  <= 1'b1;
                     state_q  <= OFFER;
                  end else begin
                     onehot_q <= '0;
                     idx_q    <= '0;
                     valid_q  <= 1'b0;
                     state_q  <= IDLE;
                  end
               end else begin
                  onehot_q <= onehot_q;
                  idx_q    <= idx_q;
                  valid_q  <= valid_q;
                  state_q  <= OFFER;
               end
            end
            default: begin
               onehot_q <= '0;
               idx_q    <= '0;
               valid_q  <= 1'b0;
               state_q  <= IDLE;
            end
         endcase
      end
   end

   assign gnt.grant_onehot = onehot_q;
   assign gnt.grant_idx    = idx_q;
   assign gnt.grant_valid  = valid_q;
   assign pending          = pending_q;
   assign overflow         = overflow_q;

endmodule
